gate_sweep_ctrl: RTL and testbench

Sequencer that exercises a two-input combinational gate block (inputs `w`, `x`; output `y`) through its four input vectors. For each vector it drives the inputs, waits a programmable settle time, and samples `y`. The four samples are collected into a 4-bit truth table, which is optionally compared against an expected table. The block sits between a bench or self-test front end (`start`/`done` handshake) and the gate instance, and it owns the gate's inputs for the whole sweep.

---
 rtl/gate_sweep_pkg.sv | 12 +
 rtl/sweep_settle_timer.sv | 26 ++
 rtl/gate_sweep_ctrl.sv | 112 +++++++++++
 tb/tb_gate_sweep_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - shared state encodings and sizes for the gate sweep sequencer
package gate_sweep_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int CNT_W       = 8;
endpackage

// File: rtl/sweep_settle_timer.sv
// rtl/sweep_settle_timer.sv - loadable down-counter with zero flag for vector settle time
module sweep_settle_timer
    import gate_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_count;

    // Holds at zero rather than wrapping if decrement is requested past the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - sweeps a 2-input gate through its 4 vectors and captures its truth table
// Optional expected-table compare enabled by GATE_SWEEP_COMPARE_EN.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   w_out,
    output logic                   x_out,
    input  logic                   y_in,
`ifdef GATE_SWEEP_COMPARE_EN
    input  logic [NUM_VECTORS-1:0] expected,
`endif
    output logic [NUM_VECTORS-1:0] table_out,
    output logic                   pass
);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

    state_t                 r_state;
    logic [1:0]             r_index;
    logic [NUM_VECTORS-1:0] r_shadow;
`ifdef GATE_SWEEP_COMPARE_EN
    logic [NUM_VECTORS-1:0] r_expected;
`endif
    logic                   w_load;
    logic                   w_zero;
    logic [NUM_VECTORS-1:0] w_next_shadow;

    assign w_load = ((r_state == IDLE) && start) || ((r_state == SAMPLE) && (r_index != 2'd3));

    sweep_settle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (RELOAD),
        .i_dec      (r_state == DRIVE),
        .o_zero     (w_zero)
    );

    // Shadow including the sample being taken this cycle, so DONE can publish it directly.
    always_comb begin
        w_next_shadow          = r_shadow;
        w_next_shadow[r_index] = y_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_index    <= 2'd0;
            r_shadow   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            w_out      <= 1'b0;
            x_out      <= 1'b0;
            table_out  <= '0;
`ifdef GATE_SWEEP_COMPARE_EN
            r_expected <= '0;
            pass       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_index        <= 2'd0;
                        r_shadow       <= '0;
                        busy           <= 1'b1;
                        {w_out, x_out} <= 2'b00;
`ifdef GATE_SWEEP_COMPARE_EN
                        r_expected     <= expected;
`endif
                        r_state        <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (w_zero) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_shadow <= w_next_shadow;
                    if (r_index != 2'd3) begin
                        r_index        <= r_index + 2'd1;
                        {w_out, x_out} <= r_index + 2'd1;
                        r_state        <= DRIVE;
                    end else begin
                        table_out      <= w_next_shadow;
                        done           <= 1'b1;
                        {w_out, x_out} <= 2'b00;
`ifdef GATE_SWEEP_COMPARE_EN
                        pass           <= (w_next_shadow == r_expected);
`endif
                        r_state        <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifndef GATE_SWEEP_COMPARE_EN
    assign pass = 1'b0;
`endif
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - scoreboard bench for gate_sweep_ctrl with SETTLE=2, 1 and 3 instances
module tb_gate_sweep_ctrl;
`ifdef GATE_SWEEP_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    typedef struct {
        int         id;
        int         cyc;
        logic [3:0] tbl;
        logic       ps;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] st  = 3'b000;
    logic [2:0] bsy, dn, wv, xv, ps;
    logic [3:0] tb [3];
    logic [3:0] ex [3];
    logic       y0, y1, y2;
    logic       gate_and = 1'b0;
    logic [1:0] d1_1 = 2'b00, d2_1 = 2'b00, d1_3 = 2'b00, d2_3 = 2'b00;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: ideal gate. Instances 1 and 2: OR gate whose output lags its inputs by 2 cycles.
    assign y0 = gate_and ? (wv[0] & xv[0]) : (wv[0] | xv[0]);
    always @(posedge clk) begin
        d1_1 <= {wv[1], xv[1]};
        d2_1 <= d1_1;
        d1_3 <= {wv[2], xv[2]};
        d2_3 <= d1_3;
    end
    assign y1 = |d2_1;
    assign y2 = |d2_3;

    gate_sweep_ctrl #(.SETTLE(2)) u_s2 (
        .clk(clk), .rst(rst), .start(st[0]), .busy(bsy[0]), .done(dn[0]),
        .w_out(wv[0]), .x_out(xv[0]), .y_in(y0),
`ifdef GATE_SWEEP_COMPARE_EN
        .expected(ex[0]),
`endif
        .table_out(tb[0]), .pass(ps[0]));

    gate_sweep_ctrl #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(st[1]), .busy(bsy[1]), .done(dn[1]),
        .w_out(wv[1]), .x_out(xv[1]), .y_in(y1),
`ifdef GATE_SWEEP_COMPARE_EN
        .expected(ex[1]),
`endif
        .table_out(tb[1]), .pass(ps[1]));

    gate_sweep_ctrl #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(st[2]), .busy(bsy[2]), .done(dn[2]),
        .w_out(wv[2]), .x_out(xv[2]), .y_in(y2),
`ifdef GATE_SWEEP_COMPARE_EN
        .expected(ex[2]),
`endif
        .table_out(tb[2]), .pass(ps[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push_exp(input int id, input int dcyc, input logic [3:0] t, input logic p);
        exp_t e;
        e.id = id; e.cyc = dcyc; e.tbl = t; e.ps = p;
        sb.push_back(e);
    endtask

    // Pulse start for one cycle; returns with cyc at its value during cycle 1 after acceptance.
    task automatic pulse_start(input int id, output int c0);
        st[id] = 1'b1;
        @(posedge clk); #1;
        st[id] = 1'b0;
        c0 = cyc;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dn[i] === 1'b1) begin
                int k;
                k = -1;
                for (int j = 0; j < sb.size(); j++)
                    if (k < 0 && sb[j].id == i) k = j;
                if (k < 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: dut%0d done at cycle %0d, none expected", i, cyc);
                end else begin
                    chk($sformatf("done_cycle_dut%0d", i), cyc, sb[k].cyc);
                    chk($sformatf("table_dut%0d", i), {28'd0, tb[i]}, {28'd0, sb[k].tbl});
                    chk($sformatf("pass_dut%0d", i), {31'd0, ps[i]}, {31'd0, sb[k].ps});
                    sb.delete(k);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        for (int i = 0; i < 3; i++) ex[i] = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {24'd0, bsy[0], dn[0], wv[0], xv[0], ps[0], 3'b000}, 32'd0);
        chk("reset_table", {28'd0, tb[0]}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset during the second vector: everything clears at once, no done follows.
        pulse_start(0, c0);
        repeat (4) @(posedge clk);
        #3;
        chk("mid_sweep_vector", {30'd0, wv[0], xv[0]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_reset_outputs", {27'd0, bsy[0], dn[0], wv[0], xv[0], ps[0]}, 32'd0);
        chk("mid_reset_table", {28'd0, tb[0]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_table", {28'd0, tb[0]}, 32'd0);

        // OR gate, expected latched at start then changed underneath.
        ex[0] = 4'b1110;
        pulse_start(0, c0);
        push_exp(0, c0 + 12, 4'b1110, CMP);
        ex[0] = 4'b0000;
        for (int k = 1; k <= 13; k++) begin
            chk($sformatf("or_vector_c%0d", k), {30'd0, wv[0], xv[0]}, (k <= 12) ? (k - 1) / 3 : 0);
            chk($sformatf("or_busy_c%0d", k), {31'd0, bsy[0]}, 32'd1);
            @(posedge clk); #1;
        end
        chk("or_busy_after", {30'd0, bsy[0], dn[0]}, 32'd0);

        // AND gate against the OR table.
        gate_and = 1'b1;
        ex[0] = 4'b1110;
        pulse_start(0, c0);
        push_exp(0, c0 + 12, 4'b1000, 1'b0);
        repeat (16) @(posedge clk); #1;

        // Extra start pulses while busy and during DONE are dropped.
        gate_and = 1'b0;
        pulse_start(0, c0);
        push_exp(0, c0 + 12, 4'b1110, CMP);
        repeat (4) @(posedge clk); #1;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (7) @(posedge clk); #1;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (20) @(posedge clk); #1;

        // start held high, SETTLE=1: done every 10 cycles; lagging gate yields stale table.
        ex[1] = 4'b1110;
        st[1] = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        push_exp(1, c0 + 8, 4'b1100, 1'b0);
        push_exp(1, c0 + 18, 4'b1100, 1'b0);
        push_exp(1, c0 + 28, 4'b1100, 1'b0);
        repeat (21) @(posedge clk); #1;
        st[1] = 1'b0;
        repeat (15) @(posedge clk); #1;

        // SETTLE=3 with the same lagging gate captures the correct table.
        ex[2] = 4'b1110;
        pulse_start(2, c0);
        push_exp(2, c0 + 16, 4'b1110, CMP);
        repeat (25) @(posedge clk); #1;

        chk("pending_done_count", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
